rv_exec_unit: RTL and testbench
===============================

Name: rv_exec_unit

Overview:
- Execute stage of the multi-cycle RV32I core; sits directly downstream of fetch/decode/register-read.
- Consumes the latched instruction, rs1/rs2 operand values and PC.
- Produces the write-back value and enable, plus the next PC, for the register bank and the PC register.
- Non-shift ops complete in one cycle; shifts are iterative (a few bits per cycle) to save area on small FPGAs.

Parameters:
SHIFT_STEP, 1, bits shifted per cycle in iterative mode; legal values 1, 2, 4, 8.

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from the EXECUTE state; operands valid in the same cycle
instr  in  32  current instruction word
rs1  in  32  value of register rs1
rs2  in  32  value of register rs2
pc  in  32  byte address of instr
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse; result outputs valid
wb_en  out  1  write-back enable, qualified by done
wb_data  out  32  value to write to rd
next_pc  out  32  PC for the next fetch
illegal  out  1  unsupported or misaligned; qualified by done

Behaviour:
- Reset (async, resetn=0): state IDLE; busy=0, done=0, wb_en=0, illegal=0, wb_data=0, next_pc=0, shift counter=0.
- Decode uses opcode bits [6:0], funct3 [14:12], funct7 bit 30, and the I/S/B/U/J immediates of RV32I.
- States:
  - IDLE: on start, latch instr, rs1, rs2, pc.
    - Shift op with shamt>0 -> SHIFT, busy=1.
    - All other ops -> compute result; done=1 in the next cycle; stay IDLE.
  - SHIFT: each cycle, shift by min(remaining, SHIFT_STEP) and decrement remaining by that amount. At 0 -> DONE.
  - DONE: registered outputs valid; done=1 for one cycle; busy=0 -> IDLE.
- Latency (start at cycle T):
  - non-shift, or shift with shamt=0: done at T+1.
  - shift: done at T+2+ceil(shamt/SHIFT_STEP)-1.
- shamt source: ALUreg uses rs2[4:0]; ALUimm uses instr[24:20].
- ALUreg/ALUimm ops: ADD, SUB (funct7[5], reg form only), SLL, SLT, SLTU, XOR, SRL, SRA (funct7[5]), OR, AND.
  - Arithmetic is 32-bit modulo; no flags.
  - SRA fills with rs1[31].
- LUI: wb_data = Uimm.
- AUIPC: wb_data = pc + Uimm.
- JAL: wb_data = pc + 4; next_pc = pc + Jimm.
- JALR: wb_data = pc + 4; next_pc = (rs1 + Iimm) with bit 0 cleared.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU): next_pc = taken ? pc + Bimm : pc + 4; wb_en=0.
- All other ops: next_pc = pc + 4.
- SYSTEM: next_pc = pc (halt); wb_en=0; illegal=0.
- LOAD, STORE, unknown opcode: illegal=1, wb_en=0, next_pc = pc + 4.
- Misaligned target (next_pc[1:0]!=0 on a taken jump or branch): illegal=1, wb_en=0; next_pc is still reported.
- wb_en=1 only with done, on a writing op, when rd!=0. wb_en is 0 in every cycle where done=0.
- wb_data and next_pc hold their last values between done pulses.
- start while busy=1 or during the done cycle: ignored; no state change.
- resetn deasserted mid-shift: operation is abandoned; no done pulse is produced.

Optional Feature:
BARREL_SHIFT_EN
- Defined: shifts use a combinational 32-bit barrel shifter; every op, including any shamt, has done at T+1; SHIFT state is unused; SHIFT_STEP is ignored.
- Undefined: iterative shifting exactly as described above.

Test Plan:
- Reset then idle: hold resetn=0 for 3 cycles -> all outputs 0; pulse start with resetn=0 -> no done.
- addi x1,x1,1 (0x00108093), rs1=41, pc=0x10, start -> done at T+1, wb_en=1, wb_data=42, next_pc=0x14, busy never 1.
- sub x3,x1,x2 (0x402081B3), rs1=5, rs2=7 -> wb_data=0xFFFFFFFE. The same instruction with rd=0 -> wb_en=0.
- sra x5,x1,x2 (0x4020D2B3), rs1=0x80000000, rs2=5, SHIFT_STEP=1 -> busy T+1..T+5, done at T+6, wb_data=0xFC000000. A start pulse at T+3 is ignored. Repeat with rs2=0 -> done at T+1, wb_data=0x80000000.
- beq x1,x2,+8 (0x00208463), pc=0x20: rs1=rs2=3 -> next_pc=0x28, wb_en=0; rs2=4 -> next_pc=0x24.
- jal x1,+16 (0x010000EF), pc=0x40 -> wb_data=0x44, next_pc=0x50. Load 0x0000A103 -> illegal=1, wb_en=0. resetn pulsed at T+2 of a 5-bit shift -> no done, outputs 0.

Source files
------------

// File: rtl/rv_exec_unit.sv
// Execute stage of the multi-cycle RV32I core: ALU, branch/jump resolution, write-back and next PC.
// Define BARREL_SHIFT_EN for single-cycle shifts; by default shifts run SHIFT_STEP bits per cycle.
module rv_exec_unit #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [31:0] next_pc,
    output logic        illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned SHW  = 5;
`ifdef BARREL_SHIFT_EN
    localparam bit ITER_SHIFT = 1'b0;
`else
    localparam bit ITER_SHIFT = 1'b1;
`endif

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wb_en_q, wb_en_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [XLEN-1:0]   next_pc_q, next_pc_d;
    logic [XLEN-1:0]   sh_q, sh_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              sh_left_q, sh_left_d;
    logic              sh_arith_q, sh_arith_d;
    logic              rd_nz_q, rd_nz_d;
    logic [XLEN-1:0]   pend_npc_q, pend_npc_d;

    // Instruction fields and immediates
    logic [6:0]      opcode_c;
    logic [2:0]      f3_c;
    logic            f7b_c;
    logic            rd_nz_c;
    logic [XLEN-1:0] imm_i_c, imm_u_c, imm_b_c, imm_j_c;
    logic [XLEN-1:0] pc_plus4_c;

    assign opcode_c   = instr[6:0];
    assign f3_c       = instr[14:12];
    assign f7b_c      = instr[30];
    assign rd_nz_c    = |instr[11:7];
    assign imm_i_c    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u_c    = {instr[31:12], 12'b0};
    assign imm_b_c    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j_c    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4_c = pc + XLEN'(4);

    logic            is_alu_c, is_reg_c;
    logic [XLEN-1:0] alu_b_c, alu_c, jalr_sum_c, target_c;
    logic [SHW-1:0]  shamt_c;
    logic            taken_c, jump_c, go_shift_c;
    logic            res_writes_c, res_illegal_c, res_wb_en_c;
    logic [XLEN-1:0] res_data_c, res_next_pc_c;

    assign is_reg_c   = (opcode_c == OP_ALUREG);
    assign is_alu_c   = is_reg_c || (opcode_c == OP_ALUIMM);
    assign alu_b_c    = is_reg_c ? rs2 : imm_i_c;
    assign shamt_c    = alu_b_c[SHW-1:0];
    assign jalr_sum_c = rs1 + imm_i_c;
    assign go_shift_c = ITER_SHIFT && is_alu_c && (f3_c == 3'b001 || f3_c == 3'b101)
                        && (shamt_c != '0);

    // Single-cycle result for everything except iterative shifts
    always_comb begin
        alu_c         = '0;
        taken_c       = 1'b0;
        jump_c        = 1'b0;
        target_c      = '0;
        res_writes_c  = 1'b0;
        res_illegal_c = 1'b0;
        res_data_c    = '0;
        res_next_pc_c = pc_plus4_c;

        case (f3_c)
            3'b000:  alu_c = (is_reg_c && f7b_c) ? rs1 - alu_b_c : rs1 + alu_b_c;
`ifdef BARREL_SHIFT_EN
            3'b001:  alu_c = rs1 << shamt_c;
            3'b101:  alu_c = f7b_c ? XLEN'($signed(rs1) >>> shamt_c) : rs1 >> shamt_c;
`else
            3'b001:  alu_c = rs1;
            3'b101:  alu_c = rs1;
`endif
            3'b010:  alu_c = {31'b0, $signed(rs1) < $signed(alu_b_c)};
            3'b011:  alu_c = {31'b0, rs1 < alu_b_c};
            3'b100:  alu_c = rs1 ^ alu_b_c;
            3'b110:  alu_c = rs1 | alu_b_c;
            default: alu_c = rs1 & alu_b_c;
        endcase

        case (f3_c)
            3'b000:  taken_c = (rs1 == rs2);
            3'b001:  taken_c = (rs1 != rs2);
            3'b100:  taken_c = ($signed(rs1) < $signed(rs2));
            3'b101:  taken_c = ($signed(rs1) >= $signed(rs2));
            3'b110:  taken_c = (rs1 < rs2);
            3'b111:  taken_c = (rs1 >= rs2);
            default: taken_c = 1'b0;
        endcase

        case (opcode_c)
            OP_LUI: begin
                res_writes_c = 1'b1;
                res_data_c   = imm_u_c;
            end
            OP_AUIPC: begin
                res_writes_c = 1'b1;
                res_data_c   = pc + imm_u_c;
            end
            OP_JAL: begin
                res_writes_c  = 1'b1;
                res_data_c    = pc_plus4_c;
                jump_c        = 1'b1;
                target_c      = pc + imm_j_c;
                res_next_pc_c = target_c;
            end
            OP_JALR: begin
                res_writes_c  = 1'b1;
                res_data_c    = pc_plus4_c;
                jump_c        = 1'b1;
                target_c      = jalr_sum_c & ~XLEN'(1);
                res_next_pc_c = target_c;
            end
            OP_BRANCH: begin
                jump_c        = taken_c;
                target_c      = pc + imm_b_c;
                res_next_pc_c = taken_c ? target_c : pc_plus4_c;
            end
            OP_ALUIMM, OP_ALUREG: begin
                res_writes_c = 1'b1;
                res_data_c   = alu_c;
            end
            OP_SYSTEM: res_next_pc_c = pc;
            default:   res_illegal_c = 1'b1;
        endcase

        // Taken control transfer to a non-word address
        if (jump_c && (target_c[1:0] != 2'b00)) begin
            res_illegal_c = 1'b1;
        end
        res_wb_en_c = res_writes_c && rd_nz_c && !res_illegal_c;
    end

    // One iteration of the multi-cycle shifter
    logic [SHW-1:0]  amt_c;
    logic [XLEN-1:0] sh_next_c;

    assign amt_c     = (cnt_q < SHW'(SHIFT_STEP)) ? cnt_q : SHW'(SHIFT_STEP);
    assign sh_next_c = sh_left_q  ? (sh_q << amt_c) :
                       sh_arith_q ? XLEN'($signed(sh_q) >>> amt_c) : (sh_q >> amt_c);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            illegal_q  <= 1'b0;
            wb_data_q  <= '0;
            next_pc_q  <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            sh_left_q  <= 1'b0;
            sh_arith_q <= 1'b0;
            rd_nz_q    <= 1'b0;
            pend_npc_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wb_en_q    <= wb_en_d;
            illegal_q  <= illegal_d;
            wb_data_q  <= wb_data_d;
            next_pc_q  <= next_pc_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            sh_left_q  <= sh_left_d;
            sh_arith_q <= sh_arith_d;
            rd_nz_q    <= rd_nz_d;
            pend_npc_q <= pend_npc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wb_en_d    = 1'b0;
        illegal_d  = 1'b0;
        wb_data_d  = wb_data_q;
        next_pc_d  = next_pc_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        sh_left_d  = sh_left_q;
        sh_arith_d = sh_arith_q;
        rd_nz_d    = rd_nz_q;
        pend_npc_d = pend_npc_q;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped
                if (start && !done_q) begin
                    if (go_shift_c) begin
                        state_d    = S_SHIFT;
                        busy_d     = 1'b1;
                        sh_d       = rs1;
                        cnt_d      = shamt_c;
                        sh_left_d  = (f3_c == 3'b001);
                        sh_arith_d = f7b_c;
                        rd_nz_d    = rd_nz_c;
                        pend_npc_d = pc_plus4_c;
                    end else begin
                        done_d    = 1'b1;
                        wb_en_d   = res_wb_en_c;
                        illegal_d = res_illegal_c;
                        wb_data_d = res_data_c;
                        next_pc_d = res_next_pc_c;
                    end
                end
            end
            S_SHIFT: begin
                sh_d  = sh_next_c;
                cnt_d = cnt_q - amt_c;
                if (cnt_q == amt_c) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    wb_en_d   = rd_nz_q;
                    wb_data_d = sh_next_c;
                    next_pc_d = pend_npc_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wb_en   = wb_en_q;
    assign illegal = illegal_q;
    assign wb_data = wb_data_q;
    assign next_pc = next_pc_q;

endmodule

// File: tb/tb_rv_exec_unit.sv
// Self-checking bench for rv_exec_unit: directed scenarios plus randomized ops against an ISA-level model.
module tb_rv_exec_unit;

    localparam int unsigned STEP = 1;
`ifdef BARREL_SHIFT_EN
    localparam bit TB_BARREL = 1'b1;
`else
    localparam bit TB_BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instr = '0, rs1 = '0, rs2 = '0, pc = '0;
    logic        busy, done, wb_en, illegal;
    logic [31:0] wb_data, next_pc;

    int checks = 0;
    int errors = 0;

    rv_exec_unit #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .resetn(resetn), .start(start), .instr(instr), .rs1(rs1), .rs2(rs2),
        .pc(pc), .busy(busy), .done(done), .wb_en(wb_en), .wb_data(wb_data),
        .next_pc(next_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic        illegal;
        logic        writes;
        logic [31:0] wb_data;
        logic [31:0] next_pc;
        int          lat;
    } exp_t;

    // Architectural result of one instruction, straight from the RV32I rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] p);
        exp_t        e;
        logic [31:0] immi, immu, immb, immj, y, tgt;
        logic        taken;
        int          sh;
        immi = 32'($signed(ins) >>> 20);
        immu = ins & 32'hFFFF_F000;
        immb = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        immj = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e.wb_en = 0; e.illegal = 0; e.writes = 0; e.wb_data = 0; e.next_pc = p + 4; e.lat = 1;
        taken = 0; tgt = 0; sh = 0;
        case (ins[6:0])
            7'h37: begin e.writes = 1; e.wb_data = immu; end
            7'h17: begin e.writes = 1; e.wb_data = p + immu; end
            7'h6F: begin e.writes = 1; e.wb_data = p + 4; e.next_pc = p + immj;
                         e.illegal = (e.next_pc % 4) != 0; end
            7'h67: begin e.writes = 1; e.wb_data = p + 4; tgt = a + immi;
                         e.next_pc = tgt - (tgt % 2); e.illegal = (e.next_pc % 4) != 0; end
            7'h63: begin
                case (ins[14:12])
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) < $signed(b));
                    3'd5: taken = !($signed(a) < $signed(b));
                    3'd6: taken = (a < b);
                    3'd7: taken = !(a < b);
                    default: taken = 0;
                endcase
                if (taken) begin e.next_pc = p + immb; e.illegal = (e.next_pc % 4) != 0; end
            end
            7'h73: e.next_pc = p;
            7'h13, 7'h33: begin
                e.writes = 1;
                y  = (ins[6:0] == 7'h33) ? b : immi;
                sh = int'(y % 32);
                case (ins[14:12])
                    3'd0: e.wb_data = (ins[6:0] == 7'h33 && ins[30]) ? a - y : a + y;
                    3'd1: e.wb_data = a << sh;
                    3'd2: e.wb_data = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: e.wb_data = (a < y) ? 32'd1 : 32'd0;
                    3'd4: e.wb_data = a ^ y;
                    3'd5: e.wb_data = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
                    3'd6: e.wb_data = a | y;
                    default: e.wb_data = a & y;
                endcase
                if ((ins[14:12] == 3'd1 || ins[14:12] == 3'd5) && sh > 0 && !TB_BARREL)
                    e.lat = 1 + (sh + int'(STEP) - 1) / int'(STEP);
            end
            default: e.illegal = 1;
        endcase
        e.wb_en = e.writes && (ins[11:7] != 0) && !e.illegal;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0, 1: begin
                r[6:0] = 7'h13;
                if (r[14:12] == 3'd1) r[31:25] = 7'h00;
                if (r[14:12] == 3'd5) r[31:25] = {1'b0, r[30], 5'b0};
            end
            2, 3: begin
                r[6:0] = 7'h33;
                r[31:25] = (r[14:12] == 3'd0 || r[14:12] == 3'd5) ? {1'b0, r[30], 5'b0} : 7'h00;
            end
            4:  r[6:0] = 7'h37;
            5:  r[6:0] = 7'h17;
            6:  r[6:0] = 7'h6F;
            7:  begin r[6:0] = 7'h67; r[14:12] = 3'd0; end
            8:  begin r[6:0] = 7'h63; if (r[14:13] == 2'b01) r[13] = 1'b0; end
            9:  r[6:0] = 7'h03;
            10: r[6:0] = 7'h23;
            default: r[6:0] = r[31] ? 7'h73 : 7'h0F;
        endcase
        return r;
    endfunction

    // Issue one start pulse and wait (bounded) for done; lat=0 means no done seen
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, output int lat, output int busy_n,
                          output logic busy_at_done, output logic leak);
        @(negedge clk);
        instr = ins; rs1 = a; rs2 = b; pc = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_n = 0; busy_at_done = 1'b0; leak = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin lat = c; busy_at_done = busy; break; end
            if (busy) busy_n++;
            if (wb_en) leak = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int done_n;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (wb_en !== 1'b0)    begin errors++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
        checks++; if (illegal !== 1'b0)  begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL reset_next_pc: got %h want 0", next_pc); end
        instr = 32'h0010_8093; rs1 = 32'd41; pc = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_n = 0;
        repeat (2) begin if (done) done_n++; @(negedge clk); end
        resetn = 1'b1;
        repeat (2) begin @(negedge clk); if (done) done_n++; end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL reset_start_ignored: got %0d done pulses want 0", done_n); end
    endtask

    task automatic test_addi();
        int lat, bn; logic bd, lk;
        run_op(32'h0010_8093, 32'd41, 32'd0, 32'h10, lat, bn, bd, lk);
        checks++; if (lat !== 1)          begin errors++; $display("FAIL addi_latency: got %0d want 1", lat); end
        checks++; if (wb_en !== 1'b1)     begin errors++; $display("FAIL addi_wb_en: got %b want 1", wb_en); end
        checks++; if (wb_data !== 32'd42) begin errors++; $display("FAIL addi_wb_data: got %h want 2a", wb_data); end
        checks++; if (next_pc !== 32'h14) begin errors++; $display("FAIL addi_next_pc: got %h want 14", next_pc); end
        checks++; if (bn !== 0 || bd !== 1'b0) begin errors++; $display("FAIL addi_busy: got %0d cycles want 0", bn); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || wb_en !== 1'b0 || wb_data !== 32'd42 || next_pc !== 32'h14) begin
            errors++; $display("FAIL addi_hold: got done=%b wb_en=%b data=%h npc=%h", done, wb_en, wb_data, next_pc); end
    endtask

    task automatic test_sub();
        int lat, bn; logic bd, lk;
        run_op(32'h4020_81B3, 32'd5, 32'd7, 32'h100, lat, bn, bd, lk);
        checks++; if (wb_data !== 32'hFFFF_FFFE || wb_en !== 1'b1) begin
            errors++; $display("FAIL sub_result: got data=%h wb_en=%b want fffffffe 1", wb_data, wb_en); end
        run_op(32'h4020_8033, 32'd5, 32'd7, 32'h104, lat, bn, bd, lk);
        checks++; if (lat !== 1 || wb_en !== 1'b0) begin
            errors++; $display("FAIL sub_rd0: got lat=%0d wb_en=%b want 1 0", lat, wb_en); end
    endtask

    task automatic test_sra();
        int exp_lat, lat, bn, extra; logic bd, lk; logic [31:0] data;
        exp_lat = TB_BARREL ? 1 : 1 + (5 + int'(STEP) - 1) / int'(STEP);
        @(negedge clk);
        instr = 32'h4020_D2B3; rs1 = 32'h8000_0000; rs2 = 32'd5; pc = 32'h200; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0; bn = 0; bd = 1'b0; data = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 3 && exp_lat > 3) begin instr = 32'h0010_8093; rs1 = 32'd0; start = 1'b1; end
            if (c == 4) start = 1'b0;
            if (done) begin lat = c; data = wb_data; bd = busy; break; end
            if (busy) bn++;
            @(negedge clk);
        end
        start = 1'b0;
        extra = 0;
        repeat (6) begin @(negedge clk); if (done) extra++; end
        checks++; if (lat !== exp_lat)           begin errors++; $display("FAIL sra_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (data !== 32'hFC00_0000)   begin errors++; $display("FAIL sra_wb_data: got %h want fc000000", data); end
        checks++; if (bn !== exp_lat - 1 || bd !== 1'b0) begin errors++; $display("FAIL sra_busy: got %0d cycles want %0d", bn, exp_lat - 1); end
        checks++; if (extra !== 0)               begin errors++; $display("FAIL sra_busy_start_ignored: got %0d extra done want 0", extra); end
        run_op(32'h4020_D2B3, 32'h8000_0000, 32'd0, 32'h300, lat, bn, bd, lk);
        checks++; if (lat !== 1 || wb_data !== 32'h8000_0000) begin
            errors++; $display("FAIL sra_shamt0: got lat=%0d data=%h want 1 80000000", lat, wb_data); end
    endtask

    task automatic test_branch();
        int lat, bn; logic bd, lk;
        run_op(32'h0020_8463, 32'd3, 32'd3, 32'h20, lat, bn, bd, lk);
        checks++; if (next_pc !== 32'h28 || wb_en !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL beq_taken: got npc=%h wb_en=%b ill=%b want 28 0 0", next_pc, wb_en, illegal); end
        run_op(32'h0020_8463, 32'd3, 32'd4, 32'h20, lat, bn, bd, lk);
        checks++; if (next_pc !== 32'h24 || wb_en !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken: got npc=%h wb_en=%b want 24 0", next_pc, wb_en); end
    endtask

    task automatic test_jal_load();
        int lat, bn; logic bd, lk;
        run_op(32'h0100_00EF, 32'd0, 32'd0, 32'h40, lat, bn, bd, lk);
        checks++; if (wb_data !== 32'h44 || next_pc !== 32'h50 || wb_en !== 1'b1) begin
            errors++; $display("FAIL jal: got data=%h npc=%h wb_en=%b want 44 50 1", wb_data, next_pc, wb_en); end
        run_op(32'h0000_A103, 32'd0, 32'd0, 32'h60, lat, bn, bd, lk);
        checks++; if (illegal !== 1'b1 || wb_en !== 1'b0 || next_pc !== 32'h64) begin
            errors++; $display("FAIL load_illegal: got ill=%b wb_en=%b npc=%h want 1 0 64", illegal, wb_en, next_pc); end
        @(negedge clk);
        checks++; if (illegal !== 1'b0 || done !== 1'b0 || next_pc !== 32'h64) begin
            errors++; $display("FAIL load_after: got ill=%b done=%b npc=%h want 0 0 64", illegal, done, next_pc); end
    endtask

    task automatic test_reset_mid_shift();
        int done_n;
        @(negedge clk);
        instr = 32'h0050_9093; rs1 = 32'h1; pc = 32'h400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || wb_data !== 32'h0 || next_pc !== 32'h0) begin
            errors++; $display("FAIL midshift_reset_outputs: got busy=%b done=%b data=%h npc=%h want 0", busy, done, wb_data, next_pc); end
        @(negedge clk);
        resetn = 1'b1;
        done_n = 0;
        repeat (12) begin @(negedge clk); if (done || busy) done_n++; end
        checks++; if (done_n !== 0) begin errors++; $display("FAIL midshift_no_done: got %0d active cycles want 0", done_n); end
    endtask

    task automatic test_random();
        int lat, bn; logic bd, lk; exp_t e; logic [31:0] ins, a, b, p;
        for (int n = 0; n < 200; n++) begin
            ins = gen_instr();
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            p = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            p = p & 32'h7FFF_FFFC;
            e = model(ins, a, b, p);
            run_op(ins, a, b, p, lat, bn, bd, lk);
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL rnd_latency %h: got %0d want %0d", ins, lat, e.lat); end
            checks++; if (wb_en !== e.wb_en || illegal !== e.illegal) begin
                errors++; $display("FAIL rnd_flags %h: got wb_en=%b ill=%b want %b %b", ins, wb_en, illegal, e.wb_en, e.illegal); end
            checks++; if (next_pc !== e.next_pc) begin errors++; $display("FAIL rnd_next_pc %h: got %h want %h", ins, next_pc, e.next_pc); end
            if (e.writes) begin
                checks++; if (wb_data !== e.wb_data) begin errors++; $display("FAIL rnd_wb_data %h: got %h want %h", ins, wb_data, e.wb_data); end
            end
            checks++; if (bn !== e.lat - 1 || bd !== 1'b0 || lk !== 1'b0) begin
                errors++; $display("FAIL rnd_busy %h: got busy=%0d at_done=%b leak=%b want %0d 0 0", ins, bn, bd, lk, e.lat - 1); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub();
        test_sra();
        test_branch();
        test_jal_load();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
